// File: rtl/l2_cache_pkg.sv
// Shared types and derived-width helpers for the L2 cache responder.
package l2_cache_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefBlockSize = 16;

    typedef enum logic [2:0] {
        StIdle,
        StCompare,
        StWriteBack,
        StAllocate,
        StRespond
    } l2_state_e;

    typedef logic [DefBlockSize*DefDataWidth-1:0] block_t;

    function automatic int unsigned offset_width(input int unsigned block_size);
        return $clog2(block_size);
    endfunction

    function automatic int unsigned index_width(input int unsigned cache_size,
                                                input int unsigned block_size,
                                                input int unsigned num_ways);
        return $clog2(cache_size / (block_size * num_ways));
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_width,
                                              input int unsigned cache_size,
                                              input int unsigned block_size,
                                              input int unsigned num_ways);
        return addr_width - index_width(cache_size, block_size, num_ways)
               - offset_width(block_size);
    endfunction

endpackage

// File: rtl/l2_victim_select.sv
// Victim way choice: lowest invalid way, otherwise the per-set round-robin pointer.
module l2_victim_select
    import l2_cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS = 4,
    parameter int unsigned NUM_SETS = 64,
    localparam int unsigned WayW = $clog2(NUM_WAYS),
    localparam int unsigned SetW = $clog2(NUM_SETS)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [SetW-1:0] set_i,
    input  logic [NUM_WAYS-1:0] valid_i,
    input  logic            advance_i,
    output logic [WayW-1:0] victim_o
);

    logic [NUM_SETS-1:0][WayW-1:0] ptr_q;
    logic all_valid;

    always_comb begin
        all_valid = &valid_i;
        victim_o  = ptr_q[set_i];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) victim_o = WayW'(w);
        end
    end

    // The pointer only moves when it actually picked the victim.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (advance_i && all_valid) begin
            if (ptr_q[set_i] == WayW'(NUM_WAYS - 1)) ptr_q[set_i] <= '0;
            else                                    ptr_q[set_i] <= ptr_q[set_i] + 1'b1;
        end
    end

endmodule

// File: rtl/l2_cache_responder.sv
// Set-associative write-back L2 serving block requests from L1, backed by memory.
// Optional hit/miss counters are enabled by defining L2_STATS_EN.
module l2_cache_responder
    import l2_cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CACHE_SIZE = 4096,
    parameter int unsigned BLOCK_SIZE = 16,
    parameter int unsigned NUM_WAYS   = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [ADDR_WIDTH-1:0]            l1_addr_i,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_in_i,
    input  logic                             l1_read_i,
    input  logic                             l1_write_i,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l1_data_out_o,
    output logic                             l1_ready_o,
    output logic                             l1_hit_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out_o,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in_i,
    output logic                             mem_read_o,
    output logic                             mem_write_o,
`ifdef L2_STATS_EN
    output logic [31:0]                      hit_count_o,
    output logic [31:0]                      miss_count_o,
`endif
    input  logic                             mem_ready_i
);

    localparam int unsigned BlockW  = BLOCK_SIZE * DATA_WIDTH;
    localparam int unsigned OffW    = offset_width(BLOCK_SIZE);
    localparam int unsigned IdxW    = index_width(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
    localparam int unsigned TagW    = tag_width(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
    localparam int unsigned NumSets = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
    localparam int unsigned WayW    = $clog2(NUM_WAYS);

    logic [TagW-1:0]   tag_q  [NumSets][NUM_WAYS];
    logic [BlockW-1:0] data_q [NumSets][NUM_WAYS];
    logic [NumSets-1:0][NUM_WAYS-1:0] valid_q, dirty_q;

    l2_state_e          state_q;
    logic [TagW+IdxW-1:0] addr_q;
    logic               write_q, fill_done_q;
    logic [BlockW-1:0]  wdata_q;
    logic [WayW-1:0]    victim_q;

    logic [BlockW-1:0]     l1_data_out_q, mem_data_out_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  l1_ready_q, l1_hit_q, mem_read_q, mem_write_q;

    logic [IdxW-1:0] idx;
    logic [TagW-1:0] tag;
    logic            hit;
    logic [WayW-1:0] hit_way, victim_way, arr_way;
    logic            victim_dirty, arr_we;
    logic [BlockW-1:0] arr_data;
    logic            unused_offset;

    assign unused_offset = ^l1_addr_i[OffW-1:0];
    assign idx = addr_q[IdxW-1:0];
    assign tag = addr_q[IdxW +: TagW];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WayW'(w);
            end
        end
    end

    l2_victim_select #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NumSets)
    ) u_victim (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .set_i     (idx),
        .valid_i   (valid_q[idx]),
        .advance_i (state_q == StCompare && !hit),
        .victim_o  (victim_way)
    );

    assign victim_dirty = valid_q[idx][victim_way] && dirty_q[idx][victim_way];

    always_comb begin
        arr_we   = 1'b0;
        arr_way  = victim_q;
        arr_data = wdata_q;
        case (state_q)
            StCompare: begin
                if (hit) begin
                    arr_way = hit_way;
                    arr_we  = write_q;
                end else if (write_q && !victim_dirty) begin
                    arr_way = victim_way;
                    arr_we  = 1'b1;
                end
            end
            StWriteBack: arr_we = mem_ready_i && write_q;
            StAllocate: begin
                if (!fill_done_q && mem_ready_i) begin
                    arr_we   = 1'b1;
                    arr_data = mem_data_in_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arr_we && !rst_i) begin
            tag_q[idx][arr_way]  <= tag;
            data_q[idx][arr_way] <= arr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= StIdle;
            addr_q         <= '0;
            write_q        <= 1'b0;
            wdata_q        <= '0;
            victim_q       <= '0;
            fill_done_q    <= 1'b0;
            valid_q        <= '0;
            dirty_q        <= '0;
            l1_data_out_q  <= '0;
            l1_ready_q     <= 1'b0;
            l1_hit_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (l1_read_i || l1_write_i) begin
                        addr_q  <= l1_addr_i[ADDR_WIDTH-1:OffW];
                        write_q <= l1_write_i;
                        wdata_q <= l1_data_in_i;
                        state_q <= StCompare;
                    end
                end
                StCompare: begin
                    if (hit) begin
                        if (write_q) dirty_q[idx][hit_way] <= 1'b1;
                        else         l1_data_out_q <= data_q[idx][hit_way];
                        l1_hit_q   <= 1'b1;
                        l1_ready_q <= 1'b1;
                        state_q    <= StRespond;
                    end else begin
                        victim_q <= victim_way;
                        if (victim_dirty) begin
                            mem_write_q    <= 1'b1;
                            mem_addr_q     <= {tag_q[idx][victim_way], idx, {OffW{1'b0}}};
                            mem_data_out_q <= data_q[idx][victim_way];
                            state_q        <= StWriteBack;
                        end else if (write_q) begin
                            valid_q[idx][victim_way] <= 1'b1;
                            dirty_q[idx][victim_way] <= 1'b1;
                            l1_hit_q   <= 1'b0;
                            l1_ready_q <= 1'b1;
                            state_q    <= StRespond;
                        end else begin
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {addr_q, {OffW{1'b0}}};
                            state_q    <= StAllocate;
                        end
                    end
                end
                StWriteBack: begin
                    if (mem_ready_i) begin
                        mem_write_q <= 1'b0;
                        if (write_q) begin
                            dirty_q[idx][victim_q] <= 1'b1;
                            l1_hit_q   <= 1'b0;
                            l1_ready_q <= 1'b1;
                            state_q    <= StRespond;
                        end else begin
                            dirty_q[idx][victim_q] <= 1'b0;
                            mem_read_q <= 1'b1;
                            mem_addr_q <= {addr_q, {OffW{1'b0}}};
                            state_q    <= StAllocate;
                        end
                    end
                end
                StAllocate: begin
                    // One settle cycle after the fill keeps l1_ready two cycles behind mem_ready.
                    if (fill_done_q) begin
                        fill_done_q <= 1'b0;
                        l1_hit_q    <= 1'b0;
                        l1_ready_q  <= 1'b1;
                        state_q     <= StRespond;
                    end else if (mem_ready_i) begin
                        mem_read_q             <= 1'b0;
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= 1'b0;
                        l1_data_out_q          <= mem_data_in_i;
                        fill_done_q            <= 1'b1;
                    end
                end
                StRespond: begin
                    l1_ready_q <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef L2_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == StCompare) begin
            if (hit && hit_cnt_q != 32'hFFFF_FFFF)        hit_cnt_q  <= hit_cnt_q + 1'b1;
            else if (!hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

    assign l1_data_out_o  = l1_data_out_q;
    assign l1_ready_o     = l1_ready_q;
    assign l1_hit_o       = l1_hit_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_data_out_o = mem_data_out_q;
    assign mem_read_o     = mem_read_q;
    assign mem_write_o    = mem_write_q;

endmodule

// File: tb/tb_l2_cache_responder.sv
// Directed bench for l2_cache_responder: cold/hit reads, write install, set-0 eviction, reset abort.
module tb_l2_cache_responder;
    import l2_cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] l1_addr = '0;
    block_t      l1_data_in = '0;
    logic        l1_read = 1'b0;
    logic        l1_write = 1'b0;
    block_t      l1_data_out;
    logic        l1_ready, l1_hit;
    logic [31:0] mem_addr;
    block_t      mem_data_out;
    block_t      mem_data_in = '0;
    logic        mem_read, mem_write;
    logic        mem_ready = 1'b0;
`ifdef L2_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int mem_cycles = 0;
    int ready_pulses = 0;
    logic both_seen = 1'b0;

    always #5 clk = ~clk;

    l2_cache_responder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .l1_addr_i      (l1_addr),
        .l1_data_in_i   (l1_data_in),
        .l1_read_i      (l1_read),
        .l1_write_i     (l1_write),
        .l1_data_out_o  (l1_data_out),
        .l1_ready_o     (l1_ready),
        .l1_hit_o       (l1_hit),
        .mem_addr_o     (mem_addr),
        .mem_data_out_o (mem_data_out),
        .mem_data_in_i  (mem_data_in),
        .mem_read_o     (mem_read),
        .mem_write_o    (mem_write),
`ifdef L2_STATS_EN
        .hit_count_o    (hit_count),
        .miss_count_o   (miss_count),
`endif
        .mem_ready_i    (mem_ready)
    );

    always @(posedge clk) begin
        if (mem_read || mem_write) mem_cycles <= mem_cycles + 1;
        if (l1_ready)              ready_pulses <= ready_pulses + 1;
        if (mem_read && mem_write) both_seen <= 1'b1;
    end

    function automatic block_t pat(input logic [31:0] base);
        block_t b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = base + 32'(i);
        return b;
    endfunction

    function automatic block_t fill(input logic [31:0] v);
        block_t b;
        for (int i = 0; i < 16; i++) b[i*32 +: 32] = v;
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input block_t obs, input block_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic l1_req(input logic [31:0] addr, input logic wr, input block_t d);
        l1_addr    = addr;
        l1_data_in = d;
        l1_read    = !wr;
        l1_write   = wr;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!l1_ready && n < 40);
        l1_read  = 1'b0;
        l1_write = 1'b0;
        check("ready_seen", block_t'(l1_ready), block_t'(1'b1));
    endtask

    task automatic wait_mem(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(mem_read || mem_write) && n < 40);
        check("mem_req_seen", block_t'(mem_read || mem_write), block_t'(1'b1));
    endtask

    task automatic mem_reply(input block_t d);
        repeat (4) tick();
        mem_ready   = 1'b1;
        mem_data_in = d;
        tick();
        mem_ready   = 1'b0;
        mem_data_in = '0;
    endtask

    initial begin
        int n;
        int snap;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", block_t'(l1_ready), '0);
        check("rst_hit", block_t'(l1_hit), '0);
        check("rst_mem_rw", block_t'({mem_read, mem_write}), '0);
        check("rst_mem_addr", block_t'(mem_addr), '0);
        check("rst_data_out", l1_data_out, '0);

        // 1: cold read 0x1000
        l1_req(32'h0000_1000, 1'b0, '0);
        wait_mem(n);
        check("cold_mem_lat", block_t'(n), block_t'(2));
        check("cold_mem_read", block_t'({mem_read, mem_write}), block_t'(2'b10));
        check("cold_mem_addr", block_t'(mem_addr), block_t'(32'h0000_1000));
        mem_reply(pat(32'hA5A5_0000));
        check("cold_rd_drop", block_t'(mem_read), '0);
        wait_ready(n);
        check("cold_fill_lat", block_t'(n), block_t'(1));
        check("cold_hit", block_t'(l1_hit), '0);
        check("cold_data", l1_data_out, pat(32'hA5A5_0000));
        tick();
        check("cold_pulse", block_t'(l1_ready), '0);

        // 2: repeat read hits
        snap = mem_cycles;
        l1_req(32'h0000_1000, 1'b0, '0);
        wait_ready(n);
        check("hit_lat", block_t'(n), block_t'(2));
        check("hit_flag", block_t'(l1_hit), block_t'(1'b1));
        check("hit_data", l1_data_out, pat(32'hA5A5_0000));
        tick();
        check("hit_no_mem", block_t'(mem_cycles - snap), '0);

        // 3: clean write miss installs without memory, then read hits
        snap = mem_cycles;
        l1_req(32'h0000_2010, 1'b1, fill(32'h1111_1111));
        wait_ready(n);
        check("wr_lat", block_t'(n), block_t'(2));
        check("wr_hit", block_t'(l1_hit), '0);
        tick();
        l1_req(32'h0000_2010, 1'b0, '0);
        wait_ready(n);
        check("wr_rd_hit", block_t'(l1_hit), block_t'(1'b1));
        check("wr_rd_data", l1_data_out, fill(32'h1111_1111));
        tick();
        check("wr_no_mem", block_t'(mem_cycles - snap), '0);
`ifdef L2_STATS_EN
        check("hit_count", block_t'(hit_count), block_t'(2));
        check("miss_count", block_t'(miss_count), block_t'(2));
`endif

        // 4: fill set 0 with dirty lines, then force evictions
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            l1_req(32'(t) << 10, 1'b1, pat(32'hB000_0000 + (32'(t) << 8)));
            wait_ready(n);
            check("set0_wr_hit", block_t'(l1_hit), '0);
            tick();
        end
        l1_req(32'h0000_1400, 1'b0, '0);
        wait_mem(n);
        check("wb0_lat", block_t'(n), block_t'(2));
        check("wb0_rw", block_t'({mem_read, mem_write}), block_t'(2'b01));
        check("wb0_addr", block_t'(mem_addr), '0);
        check("wb0_data", mem_data_out, pat(32'hB000_0000));
        mem_reply('0);
        check("wb0_then_rd", block_t'({mem_read, mem_write}), block_t'(2'b10));
        check("wb0_fill_addr", block_t'(mem_addr), block_t'(32'h0000_1400));
        mem_reply(pat(32'hC000_0000));
        wait_ready(n);
        check("wb0_hit", block_t'(l1_hit), '0);
        check("wb0_data_out", l1_data_out, pat(32'hC000_0000));
        tick();
        l1_req(32'h0000_0000, 1'b0, '0);
        wait_mem(n);
        check("wb1_rw", block_t'({mem_read, mem_write}), block_t'(2'b01));
        check("wb1_addr", block_t'(mem_addr), block_t'(32'h0000_0400));
        check("wb1_data", mem_data_out, pat(32'hB000_0100));
        mem_reply('0);
        check("wb1_fill_addr", block_t'(mem_addr), block_t'(32'h0000_0000));
        mem_reply(pat(32'hB000_0000));
        wait_ready(n);
        check("wb1_hit", block_t'(l1_hit), '0);
        check("wb1_data_out", l1_data_out, pat(32'hB000_0000));
        tick();

        // 5: reset while allocating abandons the request
        l1_req(32'h0000_5020, 1'b0, '0);
        wait_mem(n);
        check("abort_mem_addr", block_t'(mem_addr), block_t'(32'h0000_5020));
        rst     = 1'b1;
        l1_read = 1'b0;
        snap    = ready_pulses;
        tick();
        rst = 1'b0;
        check("abort_rd", block_t'(mem_read), '0);
        repeat (3) tick();
        check("abort_no_ready", block_t'(ready_pulses - snap), '0);
        l1_req(32'h0000_5020, 1'b0, '0);
        wait_mem(n);
        check("abort_remiss_lat", block_t'(n), block_t'(2));
        check("abort_remiss_rd", block_t'(mem_read), block_t'(1'b1));
        mem_reply(pat(32'hD000_0000));
        wait_ready(n);
        check("abort_remiss_hit", block_t'(l1_hit), '0);
        tick();

        check("rw_exclusive", block_t'(both_seen), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
